// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and traps on illegal opcodes or on a
// memory access that stays not-ready for too long.
module multicycle_controller #(
    parameter int SUPPORT_IMM  = 1,
    parameter int SUPPORT_JUMP = 1,
    parameter int MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic [2:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic        pc_en,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        retire,
    output logic [3:0]  state,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_IMM_EX   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BEQ_EX   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Counter must hold values up to MEM_TIMEOUT; keep at least one bit when disabled.
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // Count value seen on the last tolerated stall cycle before the trap.
    localparam logic [CNT_W-1:0] LAST_STALL = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;
    logic             r_bus_err;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_funct_legal;
    logic       w_mem_state;
    logic       w_stall;
    logic       w_timeout;
    logic       w_unused;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];
    assign w_unused = ^instr[25:6];

    assign w_funct_legal = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                           (w_funct == FN_OR)  || (w_funct == FN_SLT);

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_stall     = w_mem_state && !mem_ready;
    // A ready on the would-be timeout cycle completes the access, since w_stall is then 0.
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_stall && (r_cnt == LAST_STALL);

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of block ordering.
            r_state <= w_next;
        end
    end

    // Stall counter plus sticky illegal / bus-error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (mem_ready || (w_next != r_state)) begin
                r_cnt <= '0;
            end else if (w_stall) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == S_DECODE) && (w_next == S_TRAP)) begin
                r_illegal <= 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                case (w_opcode)
                    OP_RTYPE:                         w_next = w_funct_legal ? S_RTYPE_EX : S_TRAP;
                    OP_LW, OP_SW:                     w_next = S_MEMADR;
                    OP_BEQ:                           w_next = S_BEQ_EX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = (SUPPORT_IMM != 0) ? S_IMM_EX : S_TRAP;
                    OP_J:                             w_next = (SUPPORT_JUMP != 0) ? S_JUMP : S_TRAP;
                    default:                          w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (w_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEMWR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEMWB, S_ALU_WB, S_BEQ_EX, S_JUMP: w_next = S_FETCH;
            S_RTYPE_EX, S_IMM_EX:                w_next = S_ALU_WB;
            S_TRAP:                              w_next = S_TRAP;
            default:                             w_next = S_TRAP;
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        alu_op     = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                case (w_funct)
                    FN_SUB:  alu_op = 3'b011;
                    FN_AND:  alu_op = 3'b100;
                    FN_OR:   alu_op = 3'b010;
                    FN_SLT:  alu_op = 3'b111;
                    default: alu_op = 3'b000;
                endcase
            end
            S_IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (w_opcode)
                    OP_ANDI: alu_op = 3'b100;
                    OP_ORI:  alu_op = 3'b010;
                    OP_SLTI: alu_op = 3'b111;
                    default: alu_op = 3'b000;
                endcase
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (w_opcode == OP_RTYPE);
                retire    = 1'b1;
            end
            S_BEQ_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b011;
                pc_src    = 2'b01;
                pc_en     = zero;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Instance A: imm/jump enabled,
// MEM_TIMEOUT=4. Instance B: imm/jump disabled, timeout disabled.
// The driver pushes the expected state/control word for each cycle into a
// scoreboard queue; a separate monitor pops and compares on the falling edge.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;

    logic [2:0] a_alu_op, b_alu_op;
    logic       a_src_a, b_src_a;
    logic [1:0] a_src_b, b_src_b, a_pc_src, b_pc_src;
    logic       a_pc_en, a_ir_write, a_mem_read, a_mem_write, a_iord, a_reg_write, a_reg_dst, a_mem_to_reg;
    logic       b_pc_en, b_ir_write, b_mem_read, b_mem_write, b_iord, b_reg_write, b_reg_dst, b_mem_to_reg;
    logic       a_retire, a_illegal, a_bus_err, b_retire, b_illegal, b_bus_err;
    logic [3:0] a_state, b_state;

    multicycle_controller #(.SUPPORT_IMM(1), .SUPPORT_JUMP(1), .MEM_TIMEOUT(4)) u_dut_a (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .alu_op(a_alu_op), .alu_src_a(a_src_a), .alu_src_b(a_src_b), .pc_src(a_pc_src),
        .pc_en(a_pc_en), .ir_write(a_ir_write), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .iord(a_iord), .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
        .retire(a_retire), .state(a_state), .illegal(a_illegal), .bus_err(a_bus_err)
    );

    multicycle_controller #(.SUPPORT_IMM(0), .SUPPORT_JUMP(0), .MEM_TIMEOUT(0)) u_dut_b (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .alu_op(b_alu_op), .alu_src_a(b_src_a), .alu_src_b(b_src_b), .pc_src(b_pc_src),
        .pc_en(b_pc_en), .ir_write(b_ir_write), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .iord(b_iord), .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
        .retire(b_retire), .state(b_state), .illegal(b_illegal), .bus_err(b_bus_err)
    );

    always #5 clk = ~clk;

    // Observed word: {state, alu_op, src_a, src_b, pc_src, pc_en, ir_write, mem_read,
    //                 mem_write, iord, reg_write, reg_dst, mem_to_reg, retire, illegal, bus_err}
    logic [22:0] a_obs, b_obs;
    assign a_obs = {a_state, a_alu_op, a_src_a, a_src_b, a_pc_src, a_pc_en, a_ir_write, a_mem_read,
                    a_mem_write, a_iord, a_reg_write, a_reg_dst, a_mem_to_reg, a_retire, a_illegal, a_bus_err};
    assign b_obs = {b_state, b_alu_op, b_src_a, b_src_b, b_pc_src, b_pc_en, b_ir_write, b_mem_read,
                    b_mem_write, b_iord, b_reg_write, b_reg_dst, b_mem_to_reg, b_retire, b_illegal, b_bus_err};

    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_RTYPE = 4'd7;
    localparam logic [3:0] S_IMM = 4'd8,   S_ALUWB = 4'd9, S_BEQ = 4'd10,  S_JUMP = 4'd11, S_TRAP = 4'd15;

    localparam logic [18:0] F_SRCA = 19'h1 << 15;
    localparam logic [18:0] B_4    = 19'h1 << 13;
    localparam logic [18:0] B_IMM  = 19'h2 << 13;
    localparam logic [18:0] B_SH   = 19'h3 << 13;
    localparam logic [18:0] PC_OUT = 19'h1 << 11;
    localparam logic [18:0] PC_J   = 19'h2 << 11;
    localparam logic [18:0] F_PCEN = 19'h1 << 10;
    localparam logic [18:0] F_IRW  = 19'h1 << 9;
    localparam logic [18:0] F_MRD  = 19'h1 << 8;
    localparam logic [18:0] F_MWR  = 19'h1 << 7;
    localparam logic [18:0] F_IORD = 19'h1 << 6;
    localparam logic [18:0] F_RW   = 19'h1 << 5;
    localparam logic [18:0] F_RDST = 19'h1 << 4;
    localparam logic [18:0] F_M2R  = 19'h1 << 3;
    localparam logic [18:0] F_RET  = 19'h1 << 2;
    localparam logic [18:0] F_ILL  = 19'h1 << 1;
    localparam logic [18:0] F_BERR = 19'h1;

    localparam logic [18:0] E_FETCH_WAIT = F_MRD | B_4;
    localparam logic [18:0] E_FETCH_RDY  = F_MRD | B_4 | F_IRW | F_PCEN;
    localparam logic [18:0] E_DECODE     = B_SH;
    localparam logic [18:0] E_MEMADR     = F_SRCA | B_IMM;
    localparam logic [18:0] E_MEMRD      = F_MRD | F_IORD;
    localparam logic [18:0] E_MEMWB      = F_RW | F_M2R | F_RET;
    localparam logic [18:0] E_MEMWR      = F_MWR | F_IORD;
    localparam logic [18:0] E_WB_R       = F_RW | F_RDST | F_RET;
    localparam logic [18:0] E_WB_I       = F_RW | F_RET;
    localparam logic [18:0] E_BEQ        = F_SRCA | (19'h3 << 16) | PC_OUT | F_RET;
    localparam logic [18:0] E_JUMP       = PC_J | F_PCEN | F_RET;

    localparam logic [31:0] I_ADD = 32'h0109_5020, I_SUB = 32'h0109_5022, I_AND = 32'h0109_5024;
    localparam logic [31:0] I_OR  = 32'h0109_5025, I_SLT = 32'h0109_502A, I_ADDU = 32'h0109_5021;
    localparam logic [31:0] I_LW  = 32'h8D09_0004, I_SW  = 32'hAD09_0008, I_BEQ = 32'h1109_0003;
    localparam logic [31:0] I_ADDI = 32'h2109_0005, I_ANDI = 32'h3109_00FF, I_ORI = 32'h3509_00F0;
    localparam logic [31:0] I_SLTI = 32'h2909_0010, I_J = 32'h0800_0040;

    typedef struct {
        bit          sel;
        logic [3:0]  st;
        logic [18:0] ctl;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_ins;

    // Push an expectation for the current cycle without advancing time.
    task automatic expect_now(input bit sel, input logic [3:0] st, input logic [18:0] ctl, input string nm);
        exp_t e;
        e.sel  = sel;
        e.st   = st;
        e.ctl  = ctl;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Advance one cycle, drive inputs just after the edge, and record the expectation.
    task automatic step(input bit sel, input logic r, input logic rdy, input logic z,
                        input logic [3:0] st, input logic [18:0] ctl, input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        zero      = z;
        instr     = cur_ins;
        expect_now(sel, st, ctl, nm);
    endtask

    task automatic reset_both(input string nm);
        step(0, 1'b1, 1'b0, 1'b0, S_IDLE, 19'h0, {nm, " a in reset"});
        expect_now(1, S_IDLE, 19'h0, {nm, " b in reset"});
        step(0, 1'b0, 1'b1, 1'b0, S_IDLE, 19'h0, {nm, " a release"});
        expect_now(1, S_IDLE, 19'h0, {nm, " b release"});
    endtask

    task automatic run_rtype(input logic [31:0] ins, input logic [2:0] op, input string nm);
        cur_ins = ins;
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY,                  {nm, " fetch"});
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,                     {nm, " decode"});
        step(0, 1'b0, 1'b1, 1'b0, S_RTYPE,  F_SRCA | {op, 16'h0},         {nm, " execute"});
        step(0, 1'b0, 1'b1, 1'b0, S_ALUWB,  E_WB_R,                       {nm, " writeback"});
    endtask

    task automatic run_imm(input logic [31:0] ins, input logic [2:0] op, input string nm);
        cur_ins = ins;
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY,                  {nm, " fetch"});
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,                     {nm, " decode"});
        step(0, 1'b0, 1'b1, 1'b0, S_IMM,    F_SRCA | B_IMM | {op, 16'h0}, {nm, " execute"});
        step(0, 1'b0, 1'b1, 1'b0, S_ALUWB,  E_WB_I,                       {nm, " writeback"});
    endtask

    // Monitor: compare every expectation queued for this cycle on the falling edge.
    initial begin
        exp_t        e;
        logic [22:0] got;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = e.sel ? b_obs : a_obs;
                n_checks++;
                if (got !== {e.st, e.ctl}) begin
                    n_fail++;
                    $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                             e.name, got[22:19], got[18:0], e.st, e.ctl);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        instr     = 32'h0;
        cur_ins   = I_ADD;

        reset_both("init");

        // R-type: state 0,1,2,7,9 with retire on the 4th cycle from FETCH.
        run_rtype(I_ADD, 3'b000, "add");
        run_rtype(I_SUB, 3'b011, "sub");
        run_rtype(I_AND, 3'b100, "and");
        run_rtype(I_OR,  3'b010, "or");
        run_rtype(I_SLT, 3'b111, "slt");

        // lw with three not-ready cycles in MEMRD: retire on cycle 8.
        cur_ins = I_LW;
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY, "lw fetch");
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,    "lw decode");
        step(0, 1'b0, 1'b1, 1'b0, S_MEMADR, E_MEMADR,    "lw memadr");
        for (int i = 0; i < 3; i++)
            step(0, 1'b0, 1'b0, 1'b0, S_MEMRD, E_MEMRD,  "lw memrd wait");
        step(0, 1'b0, 1'b1, 1'b0, S_MEMRD,  E_MEMRD,     "lw memrd ready");
        step(0, 1'b0, 1'b1, 1'b0, S_MEMWB,  E_MEMWB,     "lw writeback");

        // sw with one not-ready cycle; retire on the ready cycle.
        cur_ins = I_SW;
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY,     "sw fetch");
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,        "sw decode");
        step(0, 1'b0, 1'b1, 1'b0, S_MEMADR, E_MEMADR,        "sw memadr");
        step(0, 1'b0, 1'b0, 1'b0, S_MEMWR,  E_MEMWR,         "sw memwr wait");
        step(0, 1'b0, 1'b1, 1'b0, S_MEMWR,  E_MEMWR | F_RET, "sw memwr ready");

        // beq taken, then not taken.
        cur_ins = I_BEQ;
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY,    "beq taken fetch");
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,       "beq taken decode");
        step(0, 1'b0, 1'b1, 1'b1, S_BEQ,    E_BEQ | F_PCEN, "beq taken execute");
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY,    "beq not-taken fetch");
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,       "beq not-taken decode");
        step(0, 1'b0, 1'b1, 1'b0, S_BEQ,    E_BEQ,          "beq not-taken execute");

        // Immediate ALU ops and jump with support enabled.
        run_imm(I_ADDI, 3'b000, "addi");
        run_imm(I_ANDI, 3'b100, "andi");
        run_imm(I_ORI,  3'b010, "ori");
        run_imm(I_SLTI, 3'b111, "slti");
        cur_ins = I_J;
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY, "j fetch");
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,    "j decode");
        step(0, 1'b0, 1'b1, 1'b0, S_JUMP,   E_JUMP,      "j execute");

        // Reset asserted while MEMWR holds mem_write: outputs drop within the cycle.
        cur_ins = I_SW;
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY, "sw2 fetch");
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,    "sw2 decode");
        step(0, 1'b0, 1'b1, 1'b0, S_MEMADR, E_MEMADR,    "sw2 memadr");
        step(0, 1'b0, 1'b0, 1'b0, S_MEMWR,  E_MEMWR,     "sw2 memwr wait");
        step(0, 1'b1, 1'b0, 1'b0, S_IDLE,   19'h0,       "async reset in memwr");
        step(0, 1'b0, 1'b1, 1'b0, S_IDLE,   19'h0,       "restart idle");

        // Four stalled FETCH cycles trap with bus_err.
        cur_ins = I_ADD;
        for (int i = 0; i < 4; i++)
            step(0, 1'b0, 1'b0, 1'b0, S_FETCH, E_FETCH_WAIT, "timeout fetch stall");
        step(0, 1'b0, 1'b1, 1'b0, S_TRAP, F_BERR, "timeout trap");
        step(0, 1'b0, 1'b1, 1'b0, S_TRAP, F_BERR, "timeout trap held");
        reset_both("bus_err clear");

        // Ready on the fourth FETCH cycle wins over the timeout.
        cur_ins = I_ADD;
        for (int i = 0; i < 3; i++)
            step(0, 1'b0, 1'b0, 1'b0, S_FETCH, E_FETCH_WAIT, "late ready stall");
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY,  "late ready fetch");
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,     "late ready decode");
        step(0, 1'b0, 1'b1, 1'b0, S_RTYPE,  F_SRCA,       "late ready execute");
        step(0, 1'b0, 1'b1, 1'b0, S_ALUWB,  E_WB_R,       "late ready writeback");

        // Unsupported R-type funct traps as illegal.
        cur_ins = I_ADDU;
        step(0, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY, "addu fetch");
        step(0, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,    "addu decode");
        step(0, 1'b0, 1'b1, 1'b0, S_TRAP,   F_ILL,       "addu trap");
        step(0, 1'b0, 1'b1, 1'b0, S_TRAP,   F_ILL,       "addu trap held");

        // Instance B: ori is illegal without immediate support; rst clears the flag.
        reset_both("b phase");
        cur_ins = I_ORI;
        step(1, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY, "b ori fetch");
        step(1, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,    "b ori decode");
        step(1, 1'b0, 1'b1, 1'b0, S_TRAP,   F_ILL,       "b ori trap");
        step(1, 1'b0, 1'b1, 1'b0, S_TRAP,   F_ILL,       "b ori trap held");
        step(1, 1'b0, 1'b1, 1'b0, S_TRAP,   F_ILL,       "b ori trap still held");
        reset_both("illegal clear");

        // Instance B: j is illegal without jump support.
        cur_ins = I_J;
        step(1, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY, "b j fetch");
        step(1, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,    "b j decode");
        step(1, 1'b0, 1'b1, 1'b0, S_TRAP,   F_ILL,       "b j trap");
        reset_both("b j clear");

        // Instance B: timeout disabled, a long FETCH stall never raises bus_err.
        cur_ins = I_ADD;
        for (int i = 0; i < 20; i++)
            step(1, 1'b0, 1'b0, 1'b0, S_FETCH, E_FETCH_WAIT, "b long stall");
        step(1, 1'b0, 1'b1, 1'b0, S_FETCH,  E_FETCH_RDY, "b long stall fetch");
        step(1, 1'b0, 1'b1, 1'b0, S_DECODE, E_DECODE,    "b long stall decode");
        step(1, 1'b0, 1'b1, 1'b0, S_RTYPE,  F_SRCA,      "b long stall execute");
        step(1, 1'b0, 1'b1, 1'b0, S_ALUWB,  E_WB_R,      "b long stall writeback");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
